// File: rtl/sram_access_ctrl_if.sv
// Request/response channel between the load/store stage and sram_access_ctrl.
//   master : the load/store stage (drives req_* fields, receives rsp_*)
//   slave  : the controller (drives req_ready and rsp_*, receives req_*)
//   req_valid/req_ready : valid/ready handshake, accepted when both high
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address, A_BITS+2 bits
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend (1) or sign-extend (0) loads
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : load result (0 for stores and errors)
//   rsp_err             : misaligned or illegal-size request
interface sram_access_ctrl_if #(
    parameter int A_BITS = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [A_BITS+1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Initiator-side controller for the single-port word-wide data SRAM.
// Serves one byte/half/word load or store at a time; sub-word stores use
// read-modify-write because the SRAM has no byte enables.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   nrst         : asynchronous active-low reset
//   bus          : request/response channel (slave side)
//   mem_address  : SRAM word address
//   mem_data_in  : SRAM write data
//   mem_read_en  : SRAM read strobe (data returns the following cycle)
//   mem_write_en : SRAM write strobe
//   mem_data_out : SRAM registered read data
module sram_access_ctrl #(
    parameter int A_BITS = 10,
    parameter int D_BITS = 32
) (
    input  logic                clk,
    input  logic                nrst,
    sram_access_ctrl_if.slave   bus,
    output logic [A_BITS-1:0]   mem_address,
    output logic [D_BITS-1:0]   mem_data_in,
    output logic                mem_read_en,
    output logic                mem_write_en,
    input  logic [D_BITS-1:0]   mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RCAP = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size/alignment legality; illegal size counts as an error.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed little-endian lane out of a word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of a word with the right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {lo, 3'b000};
                data = {24'd0, wd[7:0]} << {lo, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {lo[1], 4'b0000};
                data = {16'd0, wd} << {lo[1], 4'b0000};
            end
            default: begin
                mask = 32'h0000_0000;
                data = 32'h0000_0000;
            end
        endcase
        return (word & ~mask) | data;
    endfunction

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [A_BITS+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [A_BITS-1:0] maddr_q, maddr_d;
    logic [31:0]       mdin_q, mdin_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        wbuf_d      = wbuf_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        maddr_d     = maddr_q;
        mdin_d      = mdin_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata[15:0];
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (is_bad_access(bus.req_size, bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!bus.req_we) begin
                        state_d = S_RD;
                    end else if (bus.req_size == SZ_WORD) begin
                        wbuf_d  = bus.req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: state_d = S_RCAP;
            S_RCAP: begin
                // Read data is only valid in the cycle right after the strobe.
                if (we_q) begin
                    wbuf_d  = store_merge(mem_data_out, addr_q[1:0], size_q, wdata_q);
                    state_d = S_WR;
                end else begin
                    rdata_d = load_extract(mem_data_out, addr_q[1:0], size_q, uns_q);
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they leave a flop.
        req_ready_d = (state_d == S_IDLE);
        rd_en_d     = (state_d == S_RD);
        wr_en_d     = (state_d == S_WR);
        rsp_valid_d = (state_d == S_RESP);

        if ((state_d == S_RD) || (state_d == S_WR)) begin
            maddr_d = addr_d[A_BITS+1:2];
        end else begin
            maddr_d = maddr_q;
        end

        if (state_d == S_WR) begin
            mdin_d = wbuf_d;
        end else begin
            mdin_d = mdin_q;
        end
    end

    // State, request latches and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 16'd0;
            wbuf_q      <= 32'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            maddr_q     <= '0;
            mdin_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            wbuf_q      <= wbuf_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            maddr_q     <= maddr_d;
            mdin_q      <= mdin_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign mem_address   = maddr_q;
    assign mem_data_in   = mdin_q;
    assign mem_read_en   = rd_en_q;
    assign mem_write_en  = wr_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

    logic        clk;
    logic        nrst;
    logic [9:0]  mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_out;
    logic [31:0] sram [0:1023];

    int errors = 0;
    int checks = 0;

    sram_access_ctrl_if #(.A_BITS(10)) bus ();

    sram_access_ctrl #(.A_BITS(10), .D_BITS(32)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .bus          (bus),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read data, zero when not reading.
    always_ff @(posedge clk) begin
        if (mem_write_en) sram[mem_address] <= mem_data_in;
        mem_data_out <= mem_read_en ? sram[mem_address] : 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and watch it until its response (bounded).
    task automatic run_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic err,
                           output int nrd, output int nwr,
                           output logic [31:0] wdin, output logic [9:0] waddr);
        lat = 0; nrd = 0; nwr = 0; rd = 32'hXXXX_XXXX; err = 1'bx;
        wdin = 32'd0; waddr = 10'd0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_size = size; bus.req_unsigned = uns; bus.req_wdata = wd;
        step();
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (mem_read_en) nrd++;
            if (mem_write_en) begin
                nwr++;
                wdin = mem_data_in;
                waddr = mem_address;
            end
            if (bus.rsp_valid) begin
                lat = i; rd = bus.rsp_rdata; err = bus.rsp_err;
                break;
            end
            step();
        end
        step();
    endtask

    int          lat, nrd, nwr;
    logic [31:0] rd, wdin;
    logic        err;
    logic [9:0]  waddr;

    initial begin
        nrst = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 12'd0;
        bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0;
        step(); step();
        // Reset state
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_strobes", {28'd0, bus.rsp_valid, bus.rsp_err, mem_read_en, mem_write_en}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_addr", {22'd0, mem_address}, 32'd0);
        check("rst_din", mem_data_in, 32'd0);
        nrst = 1'b1;
        step();

        // Word store 0xDEADBEEF to 0x010
        run_req(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, err, nrd, nwr, wdin, waddr);
        check("wst_lat", 32'(lat), 32'd2);
        check("wst_nwr", 32'(nwr), 32'd1);
        check("wst_nrd", 32'(nrd), 32'd0);
        check("wst_din", wdin, 32'hDEADBEEF);
        check("wst_addr", {22'd0, waddr}, 32'd4);
        check("wst_rsp", {rd[30:0], err}, 32'd0);
        check("rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

        // Word load back
        run_req(1'b0, 12'h010, 2'b10, 1'b1, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("wld_lat", 32'(lat), 32'd3);
        check("wld_data", rd, 32'hDEADBEEF);
        check("wld_err", {31'd0, err}, 32'd0);
        check("wld_strobes", 32'(nrd * 16 + nwr), 32'd16);

        // Sub-word loads
        run_req(1'b0, 12'h013, 2'b00, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lb_13_s", rd, 32'hFFFFFFDE);
        run_req(1'b0, 12'h013, 2'b00, 1'b1, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lb_13_u", rd, 32'h000000DE);
        run_req(1'b0, 12'h010, 2'b00, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lb_10_s", rd, 32'hFFFFFFEF);
        run_req(1'b0, 12'h010, 2'b01, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lh_10_s", rd, 32'hFFFFBEEF);
        run_req(1'b0, 12'h010, 2'b01, 1'b1, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lh_10_u", rd, 32'h0000BEEF);
        run_req(1'b0, 12'h012, 2'b01, 1'b1, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("lh_12_u", rd, 32'h0000DEAD);
        check("lh_lat", 32'(lat), 32'd3);

        // Byte store 0xAB to 0x011 (upper wdata bits must be ignored)
        run_req(1'b1, 12'h011, 2'b00, 1'b0, 32'h123456AB, lat, rd, err, nrd, nwr, wdin, waddr);
        check("sb_lat", 32'(lat), 32'd4);
        check("sb_strobes", 32'(nrd * 16 + nwr), 32'd17);
        check("sb_din", wdin, 32'hDEADABEF);
        check("sb_addr", {22'd0, waddr}, 32'd4);
        run_req(1'b0, 12'h010, 2'b10, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("sb_readback", rd, 32'hDEADABEF);

        // Half store 0xCAFE to 0x012
        run_req(1'b1, 12'h012, 2'b01, 1'b0, 32'h5555CAFE, lat, rd, err, nrd, nwr, wdin, waddr);
        check("sh_din", wdin, 32'hCAFEABEF);
        check("sh_lat", 32'(lat), 32'd4);
        run_req(1'b0, 12'h010, 2'b10, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("sh_readback", rd, 32'hCAFEABEF);

        // Error requests: misaligned half load, misaligned word store, illegal size
        run_req(1'b0, 12'h011, 2'b01, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("e_lh_lat", 32'(lat), 32'd1);
        check("e_lh_err", {31'd0, err}, 32'd1);
        check("e_lh_rdata", rd, 32'd0);
        check("e_lh_strobes", 32'(nrd + nwr), 32'd0);
        run_req(1'b1, 12'h012, 2'b10, 1'b0, 32'h11111111, lat, rd, err, nrd, nwr, wdin, waddr);
        check("e_sw_lat", 32'(lat), 32'd1);
        check("e_sw_err", {31'd0, err}, 32'd1);
        check("e_sw_strobes", 32'(nrd + nwr), 32'd0);
        run_req(1'b0, 12'h000, 2'b11, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("e_sz_lat", 32'(lat), 32'd1);
        check("e_sz_err", {31'd0, err}, 32'd1);
        check("e_sz_rdata", rd, 32'd0);
        check("e_sz_strobes", 32'(nrd + nwr), 32'd0);
        run_req(1'b0, 12'h010, 2'b10, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("e_unchanged", rd, 32'hCAFEABEF);
        check("e_clear_err", {31'd0, err}, 32'd0);

        // req_valid held through a load: single accept, next accept in C+4
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h010;
        bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        step();
        check("hold_c1_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        check("hold_c2_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        check("hold_c3", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd1);
        step();
        check("hold_c4_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        check("hold_c5_rd", {30'd0, bus.req_ready, mem_read_en}, 32'd1);
        bus.req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("hold_2nd_lat", 32'(lat), 32'd2);
        check("hold_2nd_data", bus.rsp_rdata, 32'hCAFEABEF);
        step();

        // Reset during RCAP of a byte store
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h010;
        bus.req_size = 2'b00; bus.req_wdata = 32'h00000077;
        step();
        bus.req_valid = 1'b0;
        check("mr_rd", {31'd0, mem_read_en}, 32'd1);
        step();
        nrst = 1'b0;
        #1;
        check("mr_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mr_strobes", {29'd0, bus.rsp_valid, mem_read_en, mem_write_en}, 32'd0);
        check("mr_addr", {22'd0, mem_address}, 32'd0);
        nwr = 0; nrd = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_write_en) nwr++;
            if (bus.rsp_valid) nrd++;
        end
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_write_en) nwr++;
            if (bus.rsp_valid) nrd++;
        end
        check("mr_no_wr", 32'(nwr), 32'd0);
        check("mr_no_rsp", 32'(nrd), 32'd0);
        check("mr_ready_after", {31'd0, bus.req_ready}, 32'd1);
        run_req(1'b0, 12'h010, 2'b10, 1'b0, 32'd0, lat, rd, err, nrd, nwr, wdin, waddr);
        check("mr_load_lat", 32'(lat), 32'd3);
        check("mr_load_data", rd, 32'hCAFEABEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
